// File: rtl/vga_cell_scan_if.sv
// Bundles the cell write port and the pixel/sync outputs of vga_cell_scan.
// The master side is game logic (or a bench); the slave side is the scanner.
interface vga_cell_scan_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [2:0] wr_color;
  logic [2:0] color_idx;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  modport master (
    output wr_en, wr_addr, wr_color,
    input  color_idx, hsync, vsync, video_on, frame_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_color,
    output color_idx, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/vga_cell_scan.sv
// VGA timing generator scanning an 8x8 grid of 3-bit colour cells.
// Cell row/col come from sub-counters, so no dividers are needed.
module vga_cell_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_W   = 80,
  parameter int CELL_H   = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_cell_scan_if.slave  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int CWW = $clog2(CELL_W);
  localparam int CHW = $clog2(CELL_H);

  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_SS    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_SS    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CWW-1:0] CW_LAST = CWW'(CELL_W - 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(CELL_H - 1);

  logic           pix_en;
  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [CWW-1:0] col_sub;
  logic [CHW-1:0] row_sub;
  logic [2:0]     col;
  logic [2:0]     row;
  logic [2:0]     cells [64];

  logic vis_now;
  logic hs_now;
  logic vs_now;

  assign vis_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_now  = (h_cnt >= H_SS) && (h_cnt <= H_SE);
  assign vs_now  = (v_cnt >= V_SS) && (v_cnt <= V_SE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_en <= 1'b0;
    else        pix_en <= ~pix_en;
  end

  // Sub-counters only advance inside the active area; col/row wrap
  // harmlessly past the last cell because blanking never reads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      col_sub <= '0;
      row_sub <= '0;
      col     <= 3'd0;
      row     <= 3'd0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt   <= '0;
        col_sub <= '0;
        col     <= 3'd0;
        if (v_cnt == V_LAST) begin
          v_cnt   <= '0;
          row_sub <= '0;
          row     <= 3'd0;
        end else begin
          v_cnt <= v_cnt + VW'(1);
          if (v_cnt < V_ACT) begin
            if (row_sub == CH_LAST) begin
              row_sub <= '0;
              row     <= row + 3'd1;
            end else begin
              row_sub <= row_sub + CHW'(1);
            end
          end
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
        if (h_cnt < H_ACT) begin
          if (col_sub == CW_LAST) begin
            col_sub <= '0;
            col     <= col + 3'd1;
          end else begin
            col_sub <= col_sub + CWW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) cells[i] <= 3'd0;
    end else if (bus.wr_en) begin
      cells[bus.wr_addr] <= bus.wr_color;
    end
  end

  // The read below sees the pre-write cell contents on a same-clk write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.color_idx   <= 3'd0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.video_on    <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (pix_en) begin
      bus.video_on    <= vis_now;
      bus.color_idx   <= vis_now ? cells[{row, col}] : 3'd0;
      bus.hsync       <= ~hs_now;
      bus.vsync       <= ~vs_now;
      bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      bus.frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_cell_scan.sv
// Bench for vga_cell_scan: a full-size instance and a scaled-down instance
// are checked every clk against an arithmetic model of the scan.
module tb_vga_cell_scan;

  localparam int SHA = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVA = 16, SVF = 2, SVS = 2, SVB = 2;
  localparam int SCW = 8,  SCH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_cell_scan_if d_if ();
  vga_cell_scan_if s_if ();

  vga_cell_scan dut_d (.clk(clk), .rst_n(rst_n), .bus(d_if));

  vga_cell_scan #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .CELL_W(SCW), .CELL_H(SCH)
  ) dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if));

  // ---------------- behavioural model ----------------
  logic [2:0] mcell [64];
  int         n_edge;
  logic [6:0] exp_d, exp_s;   // {color, hsync, vsync, video_on, frame_start}

  function automatic logic [6:0] pix_model(int k, int ha, int hf, int hs, int hb,
                                           int va, int vf, int vs, int vb,
                                           int cw, int ch);
    int ht, vt, h, v;
    logic vis, hsn, vsn, fs;
    logic [2:0] c;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    h   = k % ht;
    v   = (k / ht) % vt;
    vis = (h < ha) && (v < va);
    c   = vis ? mcell[(v / ch) * 8 + (h / cw)] : 3'd0;
    hsn = !((h >= ha + hf) && (h < ha + hf + hs));
    vsn = !((v >= va + vf) && (v < va + vf + vs));
    fs  = (h == 0) && (v == 0);
    return {c, hsn, vsn, vis, fs};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge <= 0;
      exp_d  <= 7'b000_1100;
      exp_s  <= 7'b000_1100;
      for (int i = 0; i < 64; i++) mcell[i] <= 3'd0;
    end else begin
      n_edge <= n_edge + 1;
      if (n_edge % 2 == 1) begin
        exp_d <= pix_model((n_edge - 1) / 2, 640, 16, 96, 48, 480, 10, 2, 33, 80, 60);
        exp_s <= pix_model((n_edge - 1) / 2, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SCW, SCH);
      end else begin
        exp_d <= {exp_d[6:1], 1'b0};
        exp_s <= {exp_s[6:1], 1'b0};
      end
      if (d_if.wr_en) mcell[d_if.wr_addr] <= d_if.wr_color;
    end
  end

  // ---------------- edge/interval measurements ----------------
  logic d_pvo = 1'b0, d_phs = 1'b1, s_pvo = 1'b0, s_phs = 1'b1, s_pvs = 1'b1;
  int d_vo_n = 0, d_vr1 = -1, d_vr2 = -1, d_hf1 = -1, d_hr1 = -1;
  int s_fs_n = 0, s_fs1 = -1, s_fs2 = -1, s_vo1 = -1, s_hf1 = -1, s_hr1 = -1;
  int s_vf1 = -1, s_vr1 = -1, s_c3 = 0, s_c7 = 0;

  always @(negedge clk) begin
    d_pvo <= d_if.video_on;
    d_phs <= d_if.hsync;
    s_pvo <= s_if.video_on;
    s_phs <= s_if.hsync;
    s_pvs <= s_if.vsync;
    if (d_if.video_on && !d_pvo) begin
      d_vo_n <= d_vo_n + 1;
      if (d_vo_n == 0) d_vr1 <= cyc;
      if (d_vo_n == 1) d_vr2 <= cyc;
    end
    if (!d_if.hsync && d_phs && d_hf1 < 0) d_hf1 <= cyc;
    if (d_if.hsync && !d_phs && d_hf1 >= 0 && d_hr1 < 0) d_hr1 <= cyc;
    if (s_if.frame_start) begin
      s_fs_n <= s_fs_n + 1;
      if (s_fs_n == 0) s_fs1 <= cyc;
      if (s_fs_n == 1) s_fs2 <= cyc;
    end
    if (s_if.video_on && !s_pvo && s_vo1 < 0) s_vo1 <= cyc;
    if (!s_if.hsync && s_phs && s_vo1 >= 0 && s_hf1 < 0) s_hf1 <= cyc;
    if (s_if.hsync && !s_phs && s_hf1 >= 0 && s_hr1 < 0) s_hr1 <= cyc;
    if (!s_if.vsync && s_pvs && s_fs1 >= 0 && s_vf1 < 0) s_vf1 <= cyc;
    if (s_if.vsync && !s_pvs && s_vf1 >= 0 && s_vr1 < 0) s_vr1 <= cyc;
    if (s_fs_n == 2 && s_if.color_idx == 3'd3) s_c3 <= s_c3 + 1;
    if (s_fs_n == 2 && s_if.color_idx == 3'd7) s_c7 <= s_c7 + 1;
  end

  // ---------------- stimulus and checks ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic write_cell(input logic [5:0] a, input logic [2:0] c);
    d_if.wr_en = 1'b1; d_if.wr_addr = a; d_if.wr_color = c;
    s_if.wr_en = 1'b1; s_if.wr_addr = a; s_if.wr_color = c;
    @(negedge clk);
    d_if.wr_en = 1'b0;
    s_if.wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_color"}, int'(d_if.color_idx), 0);
    check({tag, "_d_hsync"}, int'(d_if.hsync), 1);
    check({tag, "_d_vsync"}, int'(d_if.vsync), 1);
    check({tag, "_d_video_on"}, int'(d_if.video_on), 0);
    check({tag, "_d_frame_start"}, int'(d_if.frame_start), 0);
    check({tag, "_s_color"}, int'(s_if.color_idx), 0);
    check({tag, "_s_video_on"}, int'(s_if.video_on), 0);
    check({tag, "_s_hsync"}, int'(s_if.hsync), 1);
  endtask

  initial begin
    int guard;
    int fs_seen;
    d_if.wr_en = 1'b0; d_if.wr_addr = 6'd0; d_if.wr_color = 3'd0;
    s_if.wr_en = 1'b0; s_if.wr_addr = 6'd0; s_if.wr_color = 3'd0;

    fork
      forever begin
        @(negedge clk);
        checks++;
        if ({d_if.color_idx, d_if.hsync, d_if.vsync, d_if.video_on, d_if.frame_start} != exp_d) begin
          errors++;
          $display("FAIL cycle_full cyc=%0d got=%b expected=%b", cyc,
                   {d_if.color_idx, d_if.hsync, d_if.vsync, d_if.video_on, d_if.frame_start}, exp_d);
        end
        checks++;
        if ({s_if.color_idx, s_if.hsync, s_if.vsync, s_if.video_on, s_if.frame_start} != exp_s) begin
          errors++;
          $display("FAIL cycle_small cyc=%0d got=%b expected=%b", cyc,
                   {s_if.color_idx, s_if.hsync, s_if.vsync, s_if.video_on, s_if.frame_start}, exp_s);
        end
      end
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    write_cell(6'd9, 3'd3);
    write_cell(6'd63, 3'd7);

    // Same-clk write/read of cell 0 at pixel (3,0) of the third small frame.
    fs_seen = 0;
    guard = 0;
    while (fs_seen < 3 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (s_if.frame_start) fs_seen++;
    end
    check("wait_frame3", fs_seen, 3);
    repeat (5) @(negedge clk);
    d_if.wr_en = 1'b1; d_if.wr_addr = 6'd0; d_if.wr_color = 3'd5;
    s_if.wr_en = 1'b1; s_if.wr_addr = 6'd0; s_if.wr_color = 3'd5;
    @(negedge clk);
    d_if.wr_en = 1'b0;
    s_if.wr_en = 1'b0;
    check("wr_collide_old", int'(s_if.color_idx), 0);
    repeat (2) @(negedge clk);
    check("wr_collide_new", int'(s_if.color_idx), 5);

    while (cyc < 40000) @(negedge clk);

    check("d_line_period", d_vr2 - d_vr1, 1600);
    check("d_hsync_fall_after_video", d_hf1 - d_vr1, 1312);
    check("d_hsync_low_width", d_hr1 - d_hf1, 192);
    check("s_frame_period", s_fs2 - s_fs1, 3520);
    check("s_vsync_fall_after_fs", s_vf1 - s_fs1, 2880);
    check("s_vsync_low_width", s_vr1 - s_vf1, 320);
    check("s_hsync_fall_after_video", s_hf1 - s_vo1, 136);
    check("s_hsync_low_width", s_hr1 - s_hf1, 16);
    check("s_color3_samples", s_c3, 32);
    check("s_color7_samples", s_c7, 32);

    // Mid-line reset: outputs drop at once, scan restarts at (0,0).
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_fs_early", int'(s_if.frame_start), 0);
    @(posedge clk);
    #1;
    check("post_rst_s_fs", int'(s_if.frame_start), 1);
    check("post_rst_d_fs", int'(d_if.frame_start), 1);
    check("post_rst_s_video_on", int'(s_if.video_on), 1);
    check("post_rst_s_cell0_cleared", int'(s_if.color_idx), 0);
    repeat (400) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
